out_display: RTL
================

// Module: out_display
// PURPOSE
//  Downstream consumer of the CPU output register. Converts the 8-bit OUT value to
//  decimal (unsigned, or two's complement when signed_mode=1) with a sequential
//  double-dabble engine, then time-multiplexes four 7-segment digits: ones, tens,
//  hundreds, sign. Also shows a halted indicator.
// PARAMETERS
//  REFRESH_DIV  4  clocks per digit slot (>=1); prescaler width = $clog2(REFRESH_DIV), min 1
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset        in   1   asynchronous, active-high; clears all state immediately
//  value        in   8   CPU OUT register value
//  signed_mode  in   1   1: value is two's complement
//  halted       in   1   CPU halted flag
//  seg          out  7   {g,f,e,d,c,b,a}, active-high, registered
//  dp           out  1   decimal point, active-high, registered
//  digit_sel    out  4   one-hot digit enable, bit0=ones..bit3=sign, registered
//  bcd          out  12  {hundreds,tens,ones} last committed result
//  neg          out  1   last committed result negative
//  busy         out  1   conversion in progress
// BEHAVIOUR
//  Reset: seg=0, dp=0, digit_sel=0, bcd=0, neg=0, busy=0; state IDLE, prescaler=0,
//   digit index=0, captured {value,signed_mode}=0. No clock edge needed.
//  Converter FSM IDLE -> SHIFT -> IDLE:
//   - IDLE: if {value,signed_mode} != captured pair, on edge E0 capture pair, load
//     magnitude = (signed_mode & value[7]) ? (~value+1) : value (8-bit; 0x80 -> 128),
//     BCD scratch=0, shift count=0, busy=1, go SHIFT.
//   - SHIFT: edges E1..E8, each: add 3 to every scratch nibble >=5, then shift
//     {scratch,magnitude} left 1. On E8 commit bcd and neg, busy=0, go IDLE.
//   - Latency: bcd valid 8 clocks after capture edge; busy high exactly 8 cycles.
//   - Input changes while busy are ignored; on return to IDLE the compare against
//     the captured pair re-triggers, so the final value is never lost.
//   - neg = signed_mode & value[7] of captured pair; signed_mode toggle alone reconverts.
//  Display mux:
//   - Prescaler counts 0..REFRESH_DIV-1; on wrap, digit index advances 0,1,2,3,0.
//   - Every edge: digit_sel = 1<<index; seg = pattern for that digit from committed bcd/neg.
//   - Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F '-'=40 blank=00.
//   - Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens 0;
//     ones always shown. Sign digit '-' if neg else blank.
//   - dp = halted & (index==0); else 0.
//   - Display reads only committed bcd/neg; never shows mid-conversion scratch.
//  BCD nibbles never exceed 9; hundreds never exceeds 2.
// STRUCTURE
//  Shared package: seven-segment glyph constants, converter state encoding,
//   digit index constants (DIG_ONES, DIG_TENS, DIG_HUND, DIG_SIGN).
//  Sub-module bin2bcd_seq: capture/compare, negate, double-dabble FSM; outputs bcd,
//   neg, busy. out_display top holds prescaler, digit index, glyph mux, dp.
// TESTING
//  1. reset, value=0, signed_mode=0 -> busy never rises, bcd=000; digit_sel walks
//     0001,0010,0100,1000 every REFRESH_DIV clocks; seg 3F,00,00,00.
//  2. value=233 unsigned -> busy high 8 cycles, bcd=12'h233, neg=0; seg 4F,4F,5B,00.
//  3. signed_mode=1, value=8'hFF -> bcd=001, neg=1, sign slot seg=40;
//     value=8'h80 -> bcd=128, neg=1; signed_mode->0 with 8'h80 -> reconvert, bcd=128, neg=0.
//  4. value 5 then 7 at busy cycle 3 -> bcd=005 after 8 cycles, busy drops 1 cycle,
//     second conversion runs, final bcd=007.
//  5. halted=1 -> dp=1 only while digit_sel=0001; halted=0 -> dp=0.
//  6. async reset asserted mid-conversion, between edges -> all outputs 0 and busy=0
//     immediately; after release with value=42 -> bcd=042 within 9 clocks.

Source files
------------

// File: rtl/out_display_pkg.sv
// ============================================================================
// Module  : out_display_pkg
// Brief   : Shared glyphs, converter state encoding and digit slot indices
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package out_display_pkg;

    typedef enum logic [0:0] {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [1:0] DIG_SIGN = 2'd3;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] DD_LAST_STEP = 3'd7;

    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

`default_nettype wire

// File: rtl/out_display_bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Change-triggered sequential double-dabble converter, 8 bit -> 3 BCD
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import out_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        signed_mode,
    output logic [11:0] bcd,
    output logic        neg,
    output logic        busy
);

    conv_state_t r_state;
    logic [7:0]  r_cap_value;
    logic        r_cap_signed;
    logic [7:0]  r_mag;
    logic [11:0] r_scratch;
    logic [2:0]  r_step;
    logic        r_neg_pend;

    logic        w_is_neg;
    logic [7:0]  w_mag_in;
    logic [11:0] w_adj;
    logic [11:0] w_scratch_next;

    assign w_is_neg = signed_mode & value[7];
    assign w_mag_in = w_is_neg ? (~value + 8'd1) : value;

    for (genvar i = 0; i < 3; i++) begin : g_nib_adj
        assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                                 (r_scratch[4*i +: 4] + 4'd3) : r_scratch[4*i +: 4];
    end

    assign w_scratch_next = {w_adj[10:0], r_mag[7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= CONV_IDLE;
            r_cap_value  <= 8'd0;
            r_cap_signed <= 1'b0;
            r_mag        <= 8'd0;
            r_scratch    <= 12'd0;
            r_step       <= 3'd0;
            r_neg_pend   <= 1'b0;
            bcd          <= 12'd0;
            neg          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                CONV_IDLE: begin
                    // Inputs arriving mid-conversion are picked up here afterwards.
                    if ({value, signed_mode} != {r_cap_value, r_cap_signed}) begin
                        r_cap_value  <= value;
                        r_cap_signed <= signed_mode;
                        r_mag        <= w_mag_in;
                        r_neg_pend   <= w_is_neg;
                        r_scratch    <= 12'd0;
                        r_step       <= 3'd0;
                        busy         <= 1'b1;
                        r_state      <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_mag     <= {r_mag[6:0], 1'b0};
                    r_step    <= r_step + 3'd1;
                    if (r_step == DD_LAST_STEP) begin
                        bcd     <= w_scratch_next;
                        neg     <= r_neg_pend;
                        busy    <= 1'b0;
                        r_state <= CONV_IDLE;
                    end
                end
                default: r_state <= CONV_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/out_display.sv
// ============================================================================
// Module  : out_display
// Brief   : CPU OUT register to multiplexed 4-digit 7-segment display driver
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module out_display
    import out_display_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        signed_mode,
    input  logic        halted,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_sel,
    output logic [11:0] bcd,
    output logic        neg,
    output logic        busy
);

    localparam int              PRESC_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_idx;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_ones;
    logic [3:0]         w_tens;
    logic [3:0]         w_hund;

    bin2bcd_seq u_conv (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .signed_mode (signed_mode),
        .bcd         (bcd),
        .neg         (neg),
        .busy        (busy)
    );

    assign w_ones = bcd[3:0];
    assign w_tens = bcd[7:4];
    assign w_hund = bcd[11:8];

    // Only committed results feed the glyphs, so scratch never reaches the pins.
    always_comb begin
        w_seg_next = SEG_BLANK;
        case (r_idx)
            DIG_ONES: w_seg_next = seg_glyph(w_ones);
            DIG_TENS: w_seg_next = (w_hund == 4'd0 && w_tens == 4'd0) ? SEG_BLANK : seg_glyph(w_tens);
            DIG_HUND: w_seg_next = (w_hund == 4'd0) ? SEG_BLANK : seg_glyph(w_hund);
            DIG_SIGN: w_seg_next = neg ? SEG_MINUS : SEG_BLANK;
            default:  w_seg_next = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_idx     <= DIG_ONES;
            seg       <= SEG_BLANK;
            dp        <= 1'b0;
            digit_sel <= 4'd0;
        end else begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
            digit_sel <= 4'd1 << r_idx;
            seg       <= w_seg_next;
            dp        <= halted & (r_idx == DIG_ONES);
        end
    end

endmodule

`default_nettype wire
